// File: rtl/mem_wb_stage_pkg.sv
// Shared definitions for the MEM->WB stage: datapath widths, load-op codes,
// the registered control payload and the alignment rule for loads.
package mem_wb_stage_pkg;

   localparam int unsigned REG_DW = 32;
   localparam int unsigned REG_AW = 5;
   localparam int unsigned LDOP_W = 3;

   localparam logic [LDOP_W-1:0] LDOP_LB  = 3'b000;
   localparam logic [LDOP_W-1:0] LDOP_LBU = 3'b001;
   localparam logic [LDOP_W-1:0] LDOP_LH  = 3'b010;
   localparam logic [LDOP_W-1:0] LDOP_LHU = 3'b011;
   localparam logic [LDOP_W-1:0] LDOP_LW  = 3'b100;

   // Width-independent control carried from MEM into WB.
   typedef struct packed {
      logic              wreg;
      logic              load;
      logic [LDOP_W-1:0] ldop;
      logic [1:0]        addr_lo;
   } wb_ctrl_t;

   localparam wb_ctrl_t WB_CTRL_NOP = '0;

   // Halfword loads need an even address, word loads a word-aligned one.
   function automatic logic is_misaligned(input logic [LDOP_W-1:0] ldop,
                                          input logic [1:0]        addr_lo);
      logic mis;
      mis = 1'b0;
      if ((ldop == LDOP_LH) || (ldop == LDOP_LHU)) mis = addr_lo[0];
      else if (ldop == LDOP_LW)                    mis = (addr_lo != 2'b00);
      return mis;
   endfunction

endpackage

// File: rtl/mem_wb_stage_if.sv
// MEM->WB bus: MEM-side results, RAM read data and the GPR write port.
// HI/LO signals exist only when MEMWB_HILO_EN is defined.
interface mem_wb_stage_if #(
   parameter int unsigned DW = 32,
   parameter int unsigned AW = 5
);
   logic          mem_wreg_i;
   logic [AW-1:0] mem_wd_i;
   logic [DW-1:0] mem_wdata_i;
   logic          mem_load_i;
   logic [2:0]    mem_ldop_i;
   logic [1:0]    mem_addr_lo_i;
   logic [DW-1:0] ram_rdata_i;

   logic          wb_wreg_o;
   logic [AW-1:0] wb_wd_o;
   logic [DW-1:0] wb_wdata_o;
   logic          wb_misalign_o;

`ifdef MEMWB_HILO_EN
   logic          mem_whilo_i;
   logic [DW-1:0] mem_hi_i;
   logic [DW-1:0] mem_lo_i;
   logic          wb_whilo_o;
   logic [DW-1:0] wb_hi_o;
   logic [DW-1:0] wb_lo_o;
`endif

   modport master (
      output mem_wreg_i, mem_wd_i, mem_wdata_i, mem_load_i, mem_ldop_i, mem_addr_lo_i,
      output ram_rdata_i,
`ifdef MEMWB_HILO_EN
      output mem_whilo_i, mem_hi_i, mem_lo_i,
      input  wb_whilo_o, wb_hi_o, wb_lo_o,
`endif
      input  wb_wreg_o, wb_wd_o, wb_wdata_o, wb_misalign_o
   );

   modport slave (
      input  mem_wreg_i, mem_wd_i, mem_wdata_i, mem_load_i, mem_ldop_i, mem_addr_lo_i,
      input  ram_rdata_i,
`ifdef MEMWB_HILO_EN
      input  mem_whilo_i, mem_hi_i, mem_lo_i,
      output wb_whilo_o, wb_hi_o, wb_lo_o,
`endif
      output wb_wreg_o, wb_wd_o, wb_wdata_o, wb_misalign_o
   );

endinterface

// File: rtl/mem_wb_stage_load_align.sv
// Combinational load formatter: picks the addressed byte/halfword out of the
// little-endian RAM word and sign/zero-extends it; flags misalignment.
module mem_wb_stage_load_align
   import mem_wb_stage_pkg::*;
#(
   parameter int unsigned DW = REG_DW
) (
   input  logic [LDOP_W-1:0] ldop,
   input  logic [1:0]        addr_lo,
   input  logic [DW-1:0]     rdata,
   output logic [DW-1:0]     data,
   output logic              misalign,
   output logic              op_ok
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = rdata[{addr_lo, 3'b000} +: 8];
      half_sel = rdata[{addr_lo[1], 4'b0000} +: 16];
      data     = '0;
      op_ok    = 1'b1;
      misalign = is_misaligned(ldop, addr_lo);
      case (ldop)
         LDOP_LB:  data = {{(DW-8){byte_sel[7]}}, byte_sel};
         LDOP_LBU: data = {{(DW-8){1'b0}}, byte_sel};
         LDOP_LH:  data = {{(DW-16){half_sel[15]}}, half_sel};
         LDOP_LHU: data = {{(DW-16){1'b0}}, half_sel};
         LDOP_LW:  data = rdata;
         default:  op_ok = 1'b0;
      endcase
   end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM->WB pipeline register and GPR write-back formatter.
// Optional HI/LO forwarding path enabled by defining MEMWB_HILO_EN.
module mem_wb_stage
   import mem_wb_stage_pkg::*;
#(
   parameter int unsigned DW = REG_DW,
   parameter int unsigned AW = REG_AW
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           stall_i,
   input  logic           bubble_i,
   input  logic           flush_i,
   mem_wb_stage_if.slave  bus
);

   wb_ctrl_t      ctrl_q;
   logic [AW-1:0] wd_q;
   logic [DW-1:0] wdata_q;
   logic [DW-1:0] hold_data_q;
   logic          hold_valid_q;

   logic [DW-1:0] align_data;
   logic [DW-1:0] load_word;
   logic          align_mis;
   logic          align_ok;

   // Priority: rst > flush > stall > bubble > advance.
   always_ff @(posedge clk) begin
      if (rst || flush_i) begin
         ctrl_q       <= WB_CTRL_NOP;
         wd_q         <= '0;
         wdata_q      <= '0;
         hold_data_q  <= '0;
         hold_valid_q <= 1'b0;
      end else if (stall_i) begin
         // RAM output may move during a stall; freeze the first extracted word.
         if (ctrl_q.load && !hold_valid_q) begin
            hold_data_q  <= align_data;
            hold_valid_q <= 1'b1;
         end
      end else if (bubble_i) begin
         ctrl_q       <= WB_CTRL_NOP;
         wd_q         <= '0;
         wdata_q      <= '0;
         hold_data_q  <= '0;
         hold_valid_q <= 1'b0;
      end else begin
         ctrl_q.wreg    <= bus.mem_wreg_i;
         ctrl_q.load    <= bus.mem_load_i;
         ctrl_q.ldop    <= bus.mem_ldop_i;
         ctrl_q.addr_lo <= bus.mem_addr_lo_i;
         wd_q           <= bus.mem_wd_i;
         wdata_q        <= bus.mem_wdata_i;
         hold_valid_q   <= 1'b0;
      end
   end

   mem_wb_stage_load_align #(.DW(DW)) u_load_align (
      .ldop     (ctrl_q.ldop),
      .addr_lo  (ctrl_q.addr_lo),
      .rdata    (bus.ram_rdata_i),
      .data     (align_data),
      .misalign (align_mis),
      .op_ok    (align_ok)
   );

   // GPR write port: depends only on registered state and RAM read data.
   always_comb begin
      load_word         = hold_valid_q ? hold_data_q : align_data;
      bus.wb_wd_o       = wd_q;
      bus.wb_misalign_o = ctrl_q.load & align_mis;
      bus.wb_wdata_o    = wdata_q;
      bus.wb_wreg_o     = ctrl_q.wreg;
      if (ctrl_q.load) begin
         bus.wb_wdata_o = load_word;
         bus.wb_wreg_o  = ctrl_q.wreg & align_ok & ~align_mis;
      end
   end

`ifdef MEMWB_HILO_EN
   logic          whilo_q;
   logic [DW-1:0] hi_q;
   logic [DW-1:0] lo_q;

   always_ff @(posedge clk) begin
      if (rst || flush_i) begin
         whilo_q <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else if (stall_i) begin
         whilo_q <= whilo_q;
      end else if (bubble_i) begin
         whilo_q <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         whilo_q <= bus.mem_whilo_i;
         hi_q    <= bus.mem_hi_i;
         lo_q    <= bus.mem_lo_i;
      end
   end

   assign bus.wb_whilo_o = whilo_q;
   assign bus.wb_hi_o    = hi_q;
   assign bus.wb_lo_o    = lo_q;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Randomized self-checking bench for mem_wb_stage against a behavioural
// write-back model; HI/LO checks run when MEMWB_HILO_EN is defined.
module tb_mem_wb_stage;

   localparam int unsigned DW = 32;
   localparam int unsigned AW = 5;

   logic clk = 1'b0;
   logic rst;
   logic stall;
   logic bubble;
   logic flush;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   mem_wb_stage_if #(.DW(DW), .AW(AW)) bus ();

   mem_wb_stage #(.DW(DW), .AW(AW)) dut (
      .clk      (clk),
      .rst      (rst),
      .stall_i  (stall),
      .bubble_i (bubble),
      .flush_i  (flush),
      .bus      (bus)
   );

   // Expected {wreg, wd, wdata, misalign}; wdata is zeroed when misaligned
   // because the written value is meaningless then.
   function automatic logic [38:0] model_wb(input logic wreg, input logic [4:0] wd,
                                            input logic [31:0] wdata, input logic load,
                                            input logic [2:0] op, input logic [1:0] a,
                                            input logic [31:0] rd);
      int unsigned b, h;
      logic [31:0] v;
      logic mis, legal;
      if (!load) return {wreg, wd, wdata, 1'b0};
      b = (rd >> (8 * a)) & 32'd255;
      h = (rd >> (16 * (a / 2))) & 32'd65535;
      legal = (op <= 3'd4);
      mis = ((op == 3'd2 || op == 3'd3) && (a % 2 == 1)) || (op == 3'd4 && a != 2'd0);
      case (op)
         3'd0:    v = (b >= 128) ? 32'(b) - 32'd256 : 32'(b);
         3'd1:    v = 32'(b);
         3'd2:    v = (h >= 32768) ? 32'(h) - 32'd65536 : 32'(h);
         3'd3:    v = 32'(h);
         3'd4:    v = rd;
         default: v = 32'd0;
      endcase
      if (mis) v = 32'd0;
      return {wreg && legal && !mis, wd, v, mis};
   endfunction

   function automatic logic [38:0] observe();
      logic [31:0] d;
      d = bus.wb_misalign_o ? 32'd0 : bus.wb_wdata_o;
      return {bus.wb_wreg_o, bus.wb_wd_o, d, bus.wb_misalign_o};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_mem(input logic wreg, input logic [4:0] wd, input logic [31:0] wdata,
                          input logic load, input logic [2:0] op, input logic [1:0] a);
      bus.mem_wreg_i    = wreg;
      bus.mem_wd_i      = wd;
      bus.mem_wdata_i   = wdata;
      bus.mem_load_i    = load;
      bus.mem_ldop_i    = op;
      bus.mem_addr_lo_i = a;
   endtask

   task automatic test_reset();
      logic [38:0] e, o;
      rst = 1'b1;
      set_mem(1'b1, 5'd7, 32'hDEAD_BEEF, 1'b0, 3'd0, 2'd0);
      step();
      step();
      e = '0;
      o = observe();
      total++;
      if (o !== e) begin bad++; $display("FAIL reset_out got=%h want=%h", o, e); end
      rst = 1'b0;
      set_mem(1'b1, 5'd5, 32'h0000_1234, 1'b0, 3'd0, 2'd0);
      step();
      e = model_wb(1'b1, 5'd5, 32'h1234, 1'b0, 3'd0, 2'd0, 32'd0);
      o = observe();
      total++;
      if (o !== e) begin bad++; $display("FAIL addu_after_reset got=%h want=%h", o, e); end
   endtask

   task automatic test_directed_loads();
      logic [2:0]  ops [6] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd3, 3'd3};
      logic [1:0]  ads [6] = '{2'd3, 2'd3, 2'd2, 2'd1, 2'd2, 2'd1};
      logic [31:0] rds [6] = '{32'h8000_0000, 32'h8000_0000, 32'h8001_0000,
                               32'h1234_5678, 32'hBEEF_0000, 32'hBEEF_0000};
      logic [31:0] want[6] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001,
                               32'h0, 32'h0000_BEEF, 32'h0};
      logic [5:0]  wm  [6] = '{6'b10, 6'b10, 6'b10, 6'b01, 6'b10, 6'b01};
      for (int i = 0; i < 6; i++) begin
         set_mem(1'b1, 5'(i + 10), 32'h5A5A_5A5A, 1'b1, ops[i], ads[i]);
         step();
         bus.ram_rdata_i = rds[i];
         #1;
         total++;
         if (bus.wb_wreg_o !== wm[i][1] || bus.wb_misalign_o !== wm[i][0] ||
             (!wm[i][0] && bus.wb_wdata_o !== want[i])) begin
            bad++;
            $display("FAIL directed_load%0d got wreg=%b mis=%b data=%h want wreg=%b mis=%b data=%h",
                     i, bus.wb_wreg_o, bus.wb_misalign_o, bus.wb_wdata_o,
                     wm[i][1], wm[i][0], want[i]);
         end
      end
   endtask

   task automatic test_random_stream();
      logic [38:0] e, o;
      logic w, l;
      logic [4:0] wd;
      logic [31:0] wdata, rd;
      logic [2:0] op;
      logic [1:0] a;
      for (int i = 0; i < 60; i++) begin
         w = 1'($urandom);
         wd = 5'($urandom);
         wdata = $urandom;
         l = ($urandom_range(0, 2) != 0);
         op = 3'($urandom_range(0, 7));
         a = 2'($urandom);
         rd = $urandom;
         set_mem(w, wd, wdata, l, op, a);
         step();
         bus.ram_rdata_i = rd;
         #1;
         e = model_wb(w, wd, wdata, l, op, a, rd);
         o = observe();
         total++;
         if (o !== e) begin bad++; $display("FAIL random%0d op=%0d a=%0d got=%h want=%h", i, op, a, o, e); end
      end
   endtask

   task automatic test_stall_hold();
      logic [38:0] e, o;
      logic [2:0] op;
      logic [1:0] a;
      logic [31:0] r0;
      int n;
      for (int k = 0; k < 6; k++) begin
         op = (k == 0) ? 3'd4 : 3'($urandom_range(0, 4));
         a  = (op == 3'd4) ? 2'd0 : (op >= 3'd2) ? {1'($urandom), 1'b0} : 2'($urandom);
         r0 = (k == 0) ? 32'hCAFE_BABE : $urandom;
         n  = (k == 0) ? 3 : $urandom_range(1, 4);
         set_mem(1'b1, 5'd7, 32'h1111_1111, 1'b1, op, a);
         step();
         bus.ram_rdata_i = r0;
         stall = 1'b1;
         set_mem(1'b1, 5'd9, 32'h5555_5555, 1'b0, 3'd0, 2'd0);
         e = model_wb(1'b1, 5'd7, 32'h0, 1'b1, op, a, r0);
         for (int j = 0; j < n; j++) begin
            if (j > 0) begin
               step();
               bus.ram_rdata_i = (k == 0) ? 32'd0 : $urandom;
            end
            #1;
            o = observe();
            total++;
            if (o !== e) begin bad++; $display("FAIL stall_hold k=%0d cyc=%0d got=%h want=%h", k, j, o, e); end
         end
         step();
         stall = 1'b0;
         bus.ram_rdata_i = $urandom;
         #1;
         o = observe();
         total++;
         if (o !== e) begin bad++; $display("FAIL stall_last k=%0d got=%h want=%h", k, o, e); end
         step();
         e = model_wb(1'b1, 5'd9, 32'h5555_5555, 1'b0, 3'd0, 2'd0, 32'd0);
         o = observe();
         total++;
         if (o !== e) begin bad++; $display("FAIL stall_release k=%0d got=%h want=%h", k, o, e); end
      end
   endtask

   task automatic test_flush_bubble();
      logic [38:0] e, o;
      set_mem(1'b1, 5'd3, 32'h0000_AAAA, 1'b0, 3'd0, 2'd0);
      step();
      flush = 1'b1;
      stall = 1'b1;
      set_mem(1'b1, 5'd4, 32'h0000_BBBB, 1'b0, 3'd0, 2'd0);
      step();
      flush = 1'b0;
      stall = 1'b0;
      o = observe();
      total++;
      if (o !== 39'd0) begin bad++; $display("FAIL flush_over_stall got=%h want=0", o); end
      set_mem(1'b1, 5'd6, 32'h0000_6666, 1'b0, 3'd0, 2'd0);
      step();
      bubble = 1'b1;
      set_mem(1'b1, 5'd8, 32'h0000_8888, 1'b0, 3'd0, 2'd0);
      step();
      o = observe();
      total++;
      if (o !== 39'd0) begin bad++; $display("FAIL bubble_nop got=%h want=0", o); end
      bubble = 1'b0;
      set_mem(1'b1, 5'd9, 32'h0000_9999, 1'b0, 3'd0, 2'd0);
      step();
      stall = 1'b1;
      bubble = 1'b1;
      set_mem(1'b1, 5'd10, 32'h0000_AAAA, 1'b0, 3'd0, 2'd0);
      step();
      e = model_wb(1'b1, 5'd9, 32'h9999, 1'b0, 3'd0, 2'd0, 32'd0);
      o = observe();
      total++;
      if (o !== e) begin bad++; $display("FAIL stall_over_bubble got=%h want=%h", o, e); end
      stall = 1'b0;
      bubble = 1'b0;
      step();
      e = model_wb(1'b1, 5'd10, 32'hAAAA, 1'b0, 3'd0, 2'd0, 32'd0);
      o = observe();
      total++;
      if (o !== e) begin bad++; $display("FAIL resume_after_stall got=%h want=%h", o, e); end
   endtask

`ifdef MEMWB_HILO_EN
   task automatic test_hilo();
      logic [64:0] e, o;
      bus.mem_whilo_i = 1'b1;
      bus.mem_hi_i    = 32'h1;
      bus.mem_lo_i    = 32'h2;
      step();
      e = {1'b1, 32'h1, 32'h2};
      o = {bus.wb_whilo_o, bus.wb_hi_o, bus.wb_lo_o};
      total++;
      if (o !== e) begin bad++; $display("FAIL hilo_pass got=%h want=%h", o, e); end
      stall = 1'b1;
      bus.mem_hi_i = $urandom;
      bus.mem_lo_i = $urandom;
      step();
      o = {bus.wb_whilo_o, bus.wb_hi_o, bus.wb_lo_o};
      total++;
      if (o !== e) begin bad++; $display("FAIL hilo_stall got=%h want=%h", o, e); end
      stall = 1'b0;
      flush = 1'b1;
      step();
      flush = 1'b0;
      o = {bus.wb_whilo_o, bus.wb_hi_o, bus.wb_lo_o};
      total++;
      if (o !== 65'd0) begin bad++; $display("FAIL hilo_flush got=%h want=0", o); end
      bus.mem_whilo_i = 1'b0;
   endtask
`endif

   initial begin
      rst = 1'b1;
      stall = 1'b0;
      bubble = 1'b0;
      flush = 1'b0;
      bus.ram_rdata_i = '0;
      set_mem(1'b0, 5'd0, 32'd0, 1'b0, 3'd0, 2'd0);
`ifdef MEMWB_HILO_EN
      bus.mem_whilo_i = 1'b0;
      bus.mem_hi_i    = '0;
      bus.mem_lo_i    = '0;
`endif
      test_reset();
      test_directed_loads();
      test_random_stream();
      test_stall_hold();
      test_flush_bubble();
`ifdef MEMWB_HILO_EN
      test_hilo();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

endmodule
